sync_token_source: RTL and testbench

Clocked-to-asynchronous bridge sitting directly upstream of the token controller's left channel. It accepts words from a synchronous producer through a valid/ready port and buffers them in a small FIFO. Each word is issued as one 4-phase bundled-data token on `Lreq`/`Lack`, with `Ldata` held stable for the whole handshake. `Lack` is returned asynchronously by the token controller and is synchronized internally.

---
 rtl/token_src_pkg.sv | 24 ++
 rtl/token_sync.sv | 26 ++
 rtl/sync_token_source.sv | 150 +++++++++++++++
 tb/tb_sync_token_source.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/token_src_pkg.sv
// Shared definitions for the synchronous token source.
// Holds the handshake state encoding, default parameter values and the
// helper that sizes the FIFO occupancy counter.
package token_src_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    REQ   = 2'd2,
    RTZ   = 2'd3
  } token_src_state_t;

  localparam int TOKEN_SRC_DATA_W      = 32;
  localparam int TOKEN_SRC_DEPTH       = 4;
  localparam int TOKEN_SRC_SYNC_STAGES = 2;
  localparam int TOKEN_SRC_TIMEOUT     = 255;

  // Occupancy needs one extra bit so that a full FIFO (level == depth)
  // is distinguishable from an empty one.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/token_sync.sv
// N-flop synchronizer for a single asynchronous level signal.
// All stages clear to 0 on reset so a stale acknowledge never appears
// immediately after reset release.
module token_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_sr;

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_sr <= '0;
    end else begin
      sync_sr <= {sync_sr[STAGES-2:0], d};
    end
  end

  assign q = sync_sr[STAGES-1];

endmodule

// File: rtl/sync_token_source.sv
// Clocked-to-asynchronous bridge feeding a 4-phase bundled-data channel.
// Words from a valid/ready producer are buffered in a small FIFO and each
// one is issued as a single Lreq/Lack handshake with Ldata held stable.
// Optional watchdog: define TOKEN_SRC_TIMEOUT_EN to build the sticky
// timeout flag; otherwise timeout is tied to 0.
module sync_token_source
  import token_src_pkg::*;
#(
  parameter int DATA_W      = TOKEN_SRC_DATA_W,
  parameter int DEPTH       = TOKEN_SRC_DEPTH,
  parameter int SYNC_STAGES = TOKEN_SRC_SYNC_STAGES,
  parameter int TIMEOUT     = TOKEN_SRC_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          Lreq,
  input  logic                          Lack,
  output logic [DATA_W-1:0]             Ldata,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          busy,
  output logic                          timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_width(DEPTH);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              pop;
  logic              lack_s;
  token_src_state_t  state;

  token_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lack_sync (
    .clk (clk),
    .rst (rst),
    .d   (Lack),
    .q   (lack_s)
  );

  // Readiness deliberately ignores a same-cycle pop; a full FIFO waits a cycle.
  assign in_ready = !rst && (level != FULL_LEVEL);
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (level != '0) && !lack_s;
  assign busy     = (state != IDLE);

  // Storage array has no reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep level unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Handshake FSM: load data, wait one cycle of bundling margin, raise Lreq,
  // then follow the synchronized acknowledge through both phases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      Lreq  <= 1'b0;
      Ldata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state <= SETUP;
            Ldata <= mem[rd_ptr];
          end
        end
        SETUP: begin
          state <= REQ;
          Lreq  <= 1'b1;
        end
        REQ: begin
          if (lack_s) begin
            state <= RTZ;
            Lreq  <= 1'b0;
          end
        end
        RTZ: begin
          if (!lack_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          Lreq  <= 1'b0;
        end
      endcase
    end
  end

`ifdef TOKEN_SRC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1) + 1;
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT);

  logic [CW-1:0] wd_cnt;
  logic          in_handshake;

  assign in_handshake = (state == REQ) || (state == RTZ);

  // Watchdog counts cycles spent in REQ/RTZ; the flag is sticky until reset
  // and only reports, it never aborts the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (state == SETUP) begin
        wd_cnt <= '0;
      end else if (in_handshake && (wd_cnt != TIMEOUT_VAL)) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (in_handshake && ((wd_cnt + 1'b1) >= TIMEOUT_VAL)) begin
        timeout <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sync_token_source.sv
// Directed testbench for sync_token_source.
// A responder process models the token controller's acknowledge and a
// monitor records every issued token and any Ldata change during Lreq.
module tb_sync_token_source;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 4;
  localparam int SYNC    = 2;
  localparam int TIMEOUT = 20;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              Lreq;
  logic              Lack;
  logic [DATA_W-1:0] Ldata;
  logic [2:0]        level;
  logic              busy;
  logic              timeout;

  int n_checks = 0;
  int n_fail   = 0;

  logic ack_auto   = 1'b0;
  logic lack_force = 1'b0;
  int   ack_max    = 0;

  logic [DATA_W-1:0] got_q [$];
  int                stable_err = 0;

  sync_token_source #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .Lreq     (Lreq),
    .Lack     (Lack),
    .Ldata    (Ldata),
    .level    (level),
    .busy     (busy),
    .timeout  (timeout)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Controller model: either forces Lack or mirrors Lreq after a random delay.
  initial begin
    int dly;
    dly  = 0;
    Lack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!ack_auto) begin
        Lack = lack_force;
      end else if (Lreq !== Lack) begin
        if (dly == 0) begin
          Lack = Lreq;
          dly  = $urandom_range(0, ack_max);
        end else begin
          dly--;
        end
      end
    end
  end

  // Token monitor: captures Ldata on each Lreq rise and flags data changes while Lreq is high.
  initial begin
    logic              prev_lreq;
    logic [DATA_W-1:0] prev_data;
    prev_lreq = 1'b0;
    prev_data = '0;
    forever begin
      @(posedge clk);
      #3;
      if (Lreq && !prev_lreq) got_q.push_back(Ldata);
      if (Lreq && prev_lreq && (Ldata !== prev_data)) stable_err++;
      prev_lreq = Lreq;
      prev_data = Ldata;
    end
  end

  // Hard stop in case a bounded wait is ever missed.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [DATA_W-1:0] data);
    in_valid = valid;
    in_data  = data;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitLreq();
    for (int i = 0; i < 30 && !Lreq; i++) tick();
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget && !((level == 0) && !busy); i++) tick();
  endtask

  // Directed sequence.
  initial begin
    logic [DATA_W-1:0] words [1:6];
    int n0, n1, n2, s1;

    words[1] = 32'h1000_0001;
    words[2] = 32'h2000_0002;
    words[3] = 32'h3000_0003;
    words[4] = 32'h4000_0004;
    words[5] = 32'h5000_0005;
    words[6] = 32'h6000_0006;

    // Reset state
    rst = 1'b1;
    applyStimulus(1'b0, '0);
    #1;
    checkOutput("rst_lreq", Lreq, 0);
    checkOutput("rst_ldata", Ldata, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_timeout", timeout, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    checkOutput("post_rst_in_ready", in_ready, 1);
    checkOutput("post_rst_level", level, 0);

    // Single token with instantaneous acknowledge
    $display("[TB] single token");
    ack_auto = 1'b1;
    ack_max  = 0;
    applyStimulus(1'b1, 32'hDEAD_BEEF);
    tick();
    checkOutput("single_level_e0", level, 1);
    applyStimulus(1'b0, '0);
    tick();
    checkOutput("single_ldata_e1", Ldata, 32'hDEAD_BEEF);
    checkOutput("single_lreq_e1", Lreq, 0);
    checkOutput("single_busy_e1", busy, 1);
    checkOutput("single_level_e1", level, 0);
    tick();
    checkOutput("single_lreq_e2", Lreq, 1);
    tick();
    checkOutput("single_lreq_e3", Lreq, 1);
    tick();
    checkOutput("single_lreq_e4", Lreq, 1);
    tick();
    checkOutput("single_lreq_e5", Lreq, 0);
    checkOutput("single_busy_e5", busy, 1);
    tick();
    tick();
    checkOutput("single_busy_e7", busy, 1);
    tick();
    checkOutput("single_busy_e8", busy, 0);
    checkOutput("single_ldata_hold", Ldata, 32'hDEAD_BEEF);

    // Full FIFO with Lack stalled high
    $display("[TB] full fifo");
    n0 = got_q.size();
    ack_auto   = 1'b0;
    lack_force = 1'b1;
    for (int w = 1; w <= 5; w++) begin
      applyStimulus(1'b1, words[w]);
      tick();
    end
    checkOutput("full_level", level, 4);
    checkOutput("full_in_ready", in_ready, 0);
    applyStimulus(1'b1, words[6]);
    tick();
    checkOutput("full_refuse_level", level, 4);
    checkOutput("full_refuse_in_ready", in_ready, 0);
    checkOutput("full_ldata_w1", Ldata, words[1]);
    applyStimulus(1'b0, '0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("full_ldata_w1_hold", Ldata, words[1]);
    checkOutput("full_busy_stall", busy, 1);
    checkOutput("full_lreq_stall", Lreq, 0);

    // Drain the full FIFO and check delivery order
    ack_auto = 1'b1;
    waitDrain(200);
    checkOutput("full_drain_level", level, 0);
    checkOutput("full_drain_busy", busy, 0);
    checkOutput("full_token_count", got_q.size(), n0 + 5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("full_token_%0d", i + 1), got_q[n0 + i], words[i + 1]);
    end

    // Ordering with random acknowledge delay
    $display("[TB] ordering");
    n1 = got_q.size();
    s1 = stable_err;
    ack_max = 7;
    for (int v = 1; v <= 16; v++) begin
      applyStimulus(1'b1, DATA_W'(v));
      for (int i = 0; i < 200 && !in_ready; i++) tick();
      checkOutput($sformatf("order_accept_%0d", v), in_ready, 1);
      tick();
    end
    applyStimulus(1'b0, '0);
    waitDrain(1500);
    checkOutput("order_drain_busy", busy, 0);
    checkOutput("order_token_count", got_q.size(), n1 + 16);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("order_token_%0d", i + 1), got_q[n1 + i], i + 1);
    end
    checkOutput("order_ldata_stable", stable_err, s1);

    // Reset asserted during REQ
    $display("[TB] mid-handshake reset");
    ack_auto   = 1'b0;
    lack_force = 1'b0;
    ack_max    = 0;
    tick();
    applyStimulus(1'b1, 32'hA5A5_A5A5);
    tick();
    applyStimulus(1'b1, 32'h5A5A_5A5A);
    tick();
    applyStimulus(1'b0, '0);
    waitLreq();
    checkOutput("midrst_lreq_before", Lreq, 1);
    n2 = got_q.size();
    rst = 1'b1;
    #1;
    checkOutput("midrst_lreq_async", Lreq, 0);
    checkOutput("midrst_level_async", level, 0);
    checkOutput("midrst_busy_async", busy, 0);
    checkOutput("midrst_ldata_async", Ldata, 0);
    checkOutput("midrst_in_ready", in_ready, 0);
    tick();
    tick();
    rst = 1'b0;
    ack_auto = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    checkOutput("midrst_level_after", level, 0);
    checkOutput("midrst_no_stale_token", got_q.size(), n2);
    checkOutput("midrst_lreq_after", Lreq, 0);
    checkOutput("midrst_in_ready_after", in_ready, 1);

    // Watchdog
    $display("[TB] watchdog");
    ack_auto   = 1'b0;
    lack_force = 1'b0;
    tick();
    applyStimulus(1'b1, 32'hC0FF_EE00);
    tick();
    applyStimulus(1'b0, '0);
    waitLreq();
    checkOutput("wd_lreq", Lreq, 1);
`ifdef TOKEN_SRC_TIMEOUT_EN
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    checkOutput("wd_timeout_before", timeout, 0);
    tick();
    checkOutput("wd_timeout_set", timeout, 1);
    ack_auto = 1'b1;
    waitDrain(100);
    checkOutput("wd_drain_busy", busy, 0);
    checkOutput("wd_timeout_sticky", timeout, 1);
    rst = 1'b1;
    #1;
    checkOutput("wd_timeout_cleared", timeout, 0);
    tick();
    rst = 1'b0;
    tick();
`else
    for (int i = 0; i < TIMEOUT + 10; i++) tick();
    checkOutput("wd_timeout_disabled", timeout, 0);
    ack_auto = 1'b1;
    waitDrain(100);
    checkOutput("wd_drain_busy", busy, 0);
    checkOutput("wd_timeout_disabled_after", timeout, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
